// File: rtl/mul_seq32_pkg.sv
// rtl/mul_seq32_pkg.sv - shared types, constants and helpers for mul_seq32
//
// Contents:
//   WIDTH      operand width (32; no other width is supported)
//   CNT_W      iteration counter width, log2(WIDTH)
//   state_e    FSM encoding: IDLE=0, CALC=1, FIN=2
//   mag32()    operand magnitude for signed/unsigned capture
// Optional feature macro: MUL_SEQ_ZERO_SKIP_EN (see rtl/mul_seq32.sv).
package mul_seq32_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  // 0x80000000 negates to itself, which read as unsigned is exactly 2^31,
  // so the magnitude always fits in 32 unsigned bits.
  function automatic logic [WIDTH-1:0] mag32(input logic [WIDTH-1:0] v,
                                             input logic sgn);
    return (sgn && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/mul_seq32_if.sv
// rtl/mul_seq32_if.sv - request/response bundle between EX stage and mul_seq32
//
// Signals:
//   start      request pulse, sampled only while idle
//   mul_signed 1 = MULT (two's complement), 0 = MULTU
//   src1       multiplicand
//   src2       multiplier
//   cancel     pipeline flush; aborts an operation in flight
//   result     {HI, LO}, valid while ready=1, held until the next accepted start
//   ready      one-cycle pulse marking result valid
//   busy       high while an operation is in flight (EX stall request)
// Modports: master = pipeline side, slave = multiplier side.
interface mul_seq32_if;
  import mul_seq32_pkg::*;

  logic                 start;
  logic                 mul_signed;
  logic [WIDTH-1:0]     src1;
  logic [WIDTH-1:0]     src2;
  logic                 cancel;
  logic [2*WIDTH-1:0]   result;
  logic                 ready;
  logic                 busy;

  modport master (
    output start, mul_signed, src1, src2, cancel,
    input  result, ready, busy
  );

  modport slave (
    input  start, mul_signed, src1, src2, cancel,
    output result, ready, busy
  );

endinterface

// File: rtl/mul_seq32_csa32.sv
// rtl/mul_seq32_csa32.sv - full-adder cell and 32-bit 3:2 carry-save row
//
// fa:    a, b, ci -> s, co (single-bit full adder)
// csa32: x, y, z (32b) -> s, c (32b); x + y + z == s + 2*c
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

module csa32 (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic [31:0] z,
  output logic [31:0] s,
  output logic [31:0] c
);

  // c[i] carries weight 2^(i+1); the caller accounts for the shift.
  for (genvar i = 0; i < 32; i++) begin : g_fa
    fa u_fa (
      .a  (x[i]),
      .b  (y[i]),
      .ci (z[i]),
      .s  (s[i]),
      .co (c[i])
    );
  end

endmodule

// File: rtl/mul_seq32.sv
// rtl/mul_seq32.sv - iterative 32x32 MULT/MULTU unit with carry-save accumulator
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   mul_seq32_if.slave: start/mul_signed/src1/src2/cancel in,
//         result/ready/busy out
// Flow: IDLE --start--> CALC (32 iterations, one multiplier bit each)
//       --> FIN (carry-propagate add, sign fix) --> IDLE with ready pulse.
// Optional macro MUL_SEQ_ZERO_SKIP_EN: a zero operand jumps straight to FIN
// with cleared state, giving a 2-cycle latency and an identical result.
module mul_seq32
  import mul_seq32_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  mul_seq32_if.slave    bus
);

  state_e               state_q,  state_d;
  logic [CNT_W-1:0]     cnt_q,    cnt_d;
  logic [WIDTH-1:0]     mcand_q,  mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [WIDTH-1:0]     acc_s_q,  acc_s_d;
  logic [WIDTH-1:0]     acc_c_q,  acc_c_d;
  logic                 neg_q,    neg_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 ready_q,  ready_d;

  logic [WIDTH-1:0]     pp;
  logic [WIDTH-1:0]     csa_s;
  logic [WIDTH-1:0]     csa_c;
  logic [WIDTH-1:0]     hi;
  logic [2*WIDTH-1:0]   prod;
  logic [2*WIDTH-1:0]   prod_fin;

  assign pp = mplier_q[0] ? mcand_q : '0;

  csa32 u_csa (
    .x (acc_s_q),
    .y (acc_c_q),
    .z (pp),
    .s (csa_s),
    .c (csa_c)
  );

  // acc_s + acc_c never exceeds 2^32-1 after a shift, so no carry-out is lost.
  assign hi       = acc_s_q + acc_c_q;
  assign prod     = {hi, mplier_q};
  assign prod_fin = neg_q ? (~prod + 1'b1) : prod;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_s_d  = acc_s_q;
    acc_c_d  = acc_c_q;
    neg_d    = neg_q;
    result_d = result_q;
    ready_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.cancel) begin
          mcand_d  = mag32(bus.src1, bus.mul_signed);
          mplier_d = mag32(bus.src2, bus.mul_signed);
          neg_d    = bus.mul_signed & (bus.src1[WIDTH-1] ^ bus.src2[WIDTH-1]);
          acc_s_d  = '0;
          acc_c_d  = '0;
          cnt_d    = CNT_W'(WIDTH - 1);
          state_d  = ST_CALC;
`ifdef MUL_SEQ_ZERO_SKIP_EN
          if (bus.src1 == '0 || bus.src2 == '0) begin
            mcand_d  = '0;
            mplier_d = '0;
            neg_d    = 1'b0;
            cnt_d    = '0;
            state_d  = ST_FIN;
          end
`endif
        end
      end

      ST_CALC: begin
        if (bus.cancel) begin
          state_d = ST_IDLE;
        end else begin
          // Sum weight-1 bit retires into the top of the multiplier; the
          // carry row already sits one place up, so after the right shift it
          // lands at unit weight unchanged.
          acc_s_d  = {1'b0, csa_s[WIDTH-1:1]};
          acc_c_d  = csa_c;
          mplier_d = {csa_s[0], mplier_q[WIDTH-1:1]};
          if (cnt_q == '0) begin
            state_d = ST_FIN;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
        if (!bus.cancel) begin
          result_d = prod_fin;
          ready_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_s_q  <= '0;
      acc_c_q  <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_s_q  <= acc_s_d;
      acc_c_q  <= acc_c_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.result = result_q;
  assign bus.ready  = ready_q;
  assign bus.busy   = (state_q == ST_CALC) || (state_q == ST_FIN);

endmodule

// File: tb/tb_mul_seq32.sv
// tb/tb_mul_seq32.sv - self-checking bench for mul_seq32
module tb_mul_seq32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_seq32_if bus ();

  mul_seq32 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef MUL_SEQ_ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif
  localparam int ZLAT = ZS ? 2 : 34;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub;
    if (sgn) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
    end
    ua = {32'b0, a};
    ub = {32'b0, b};
    return ua * ub;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an accepted op finishes a fixed number of edges later
  // unless cancelled or reset; the result comes from plain 64-bit arithmetic.
  int          m_timer  = 0;
  logic        m_ready  = 1'b0;
  logic [63:0] m_result = '0;
  logic [63:0] m_pend   = '0;
  bit          chk_en   = 1'b0;

  always @(posedge clk) begin : model
    int          t;
    logic        r;
    logic [63:0] res, pend;
    t = m_timer; r = 1'b0; res = m_result; pend = m_pend;
    if (rst) begin
      t = 0; res = '0; pend = '0;
    end else if (t > 0) begin
      if (bus.cancel) begin
        t = 0;
      end else begin
        t = t - 1;
        if (t == 0) begin
          r = 1'b1;
          res = pend;
        end
      end
    end else if (bus.start && !bus.cancel) begin
      pend = ref_mul(bus.src1, bus.src2, bus.mul_signed);
      t = (ZS && (bus.src1 == 0 || bus.src2 == 0)) ? 1 : 33;
    end
    m_timer  <= t;
    m_ready  <= r;
    m_result <= res;
    m_pend   <= pend;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy",   {63'b0, bus.busy},  {63'b0, (m_timer > 0)});
      check("cyc_ready",  {63'b0, bus.ready}, {63'b0, m_ready});
      check("cyc_result", bus.result, m_result);
    end
  end

  // Called at a negedge; returns at the negedge where ready is seen.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, input logic [63:0] exp, input int exp_lat);
    int lat, bcnt;
    bus.start = 1'b1; bus.src1 = a; bus.src2 = b; bus.mul_signed = sgn;
    @(negedge clk);
    bus.start = 1'b0;
    lat  = 1;
    bcnt = bus.busy ? 1 : 0;
    while (!bus.ready && lat < 100) begin
      @(negedge clk);
      lat++;
      if (bus.busy) bcnt++;
    end
    check({name, "_lat"},  64'(lat), 64'(exp_lat));
    check({name, "_res"},  bus.result, exp);
    check({name, "_busy"}, 64'(bcnt), 64'(exp_lat - 1));
  endtask

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int rdy;
    bus.start = 1'b0; bus.mul_signed = 1'b0; bus.src1 = '0; bus.src2 = '0;
    bus.cancel = 1'b0;
    rst = 1'b1;

    check("pin_umax",  ref_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0), 64'hFFFF_FFFE_0000_0001);
    check("pin_neg5",  ref_mul(32'hFFFF_FFFF, 32'h5, 1'b1),          64'hFFFF_FFFF_FFFF_FFFB);
    check("pin_min2",  ref_mul(32'h8000_0000, 32'h8000_0000, 1'b1),  64'h4000_0000_0000_0000);
    check("pin_min1",  ref_mul(32'h8000_0000, 32'h1, 1'b1),          64'hFFFF_FFFF_8000_0000);

    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_result", bus.result, 64'h0);
    check("rst_ready",  {63'b0, bus.ready}, 64'h0);
    check("rst_busy",   {63'b0, bus.busy},  64'h0);
    rst = 1'b0;
    @(negedge clk);

    run_op("umax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 34);
    run_op("neg5", 32'hFFFF_FFFF, 32'h0000_0005, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 34);
    run_op("min2", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 34);
    run_op("min1", 32'h8000_0000, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_8000_0000, 34);
    @(negedge clk);

    // Cancel mid-calculation: no ready, busy drops, old result held.
    bus.start = 1'b1; bus.src1 = 32'h1234_5678; bus.src2 = 32'h9; bus.mul_signed = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    check("cancel_busy",   {63'b0, bus.busy},  64'h0);
    check("cancel_ready",  {63'b0, bus.ready}, 64'h0);
    check("cancel_result", bus.result, 64'hFFFF_FFFF_8000_0000);
    rdy = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.ready) rdy++;
    end
    check("cancel_noready", 64'(rdy), 64'h0);

    // Back-to-back: second start driven in the ready cycle of the first.
    run_op("b2b_a", 32'h3, 32'h7, 1'b0, 64'h15, 34);
    run_op("b2b_b", 32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000, 34);
    @(negedge clk);

    // Start while busy is ignored.
    bus.start = 1'b1; bus.src1 = 32'hFFFF_FFFF; bus.src2 = 32'h5; bus.mul_signed = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    bus.start = 1'b1; bus.src1 = 32'h2; bus.src2 = 32'h3; bus.mul_signed = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    rdy = 0;
    repeat (60) begin
      if (bus.ready) begin
        rdy++;
        check("midstart_res", bus.result, 64'hFFFF_FFFF_FFFF_FFFB);
      end
      @(negedge clk);
    end
    check("midstart_one_ready", 64'(rdy), 64'h1);

    // Reset 20 cycles into an operation.
    bus.start = 1'b1; bus.src1 = 32'h7; bus.src2 = 32'h9; bus.mul_signed = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_result", bus.result, 64'h0);
    check("midrst_ready",  {63'b0, bus.ready}, 64'h0);
    check("midrst_busy",   {63'b0, bus.busy},  64'h0);
    @(negedge clk);

    run_op("zero", 32'h0, 32'h1234, 1'b1, 64'h0, ZLAT);
    run_op("zero_neg", 32'hFFFF_FFF0, 32'h0, 1'b1, 64'h0, ZLAT);
    @(negedge clk);

    // Random traffic; the per-cycle compare against the model does the checking.
    for (int i = 0; i < 6000; i++) begin
      bus.start      = ($urandom_range(0, 3) == 0);
      bus.src1       = pick_op();
      bus.src2       = pick_op();
      bus.mul_signed = $urandom_range(0, 1);
      bus.cancel     = ($urandom_range(0, 63) == 0);
      rst            = ($urandom_range(0, 255) == 0);
      @(negedge clk);
    end
    bus.start = 1'b0; bus.cancel = 1'b0; rst = 1'b0;
    repeat (40) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
